// File: rtl/alu_share_ctrl.sv
// Two-requester round-robin front end for a shared 4-bit ALU.
// Adds a four-cycle shift-and-add multiply and a held response port.
module alu_share_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             CLOCK_50,
   input  logic             resetn,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [2:0]       req_op0,
   input  logic [2:0]       req_op1,
   input  logic [3:0]       req_a0,
   input  logic [3:0]       req_a1,
   input  logic [3:0]       req_b0,
   input  logic [3:0]       req_b1,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [7:0]       rsp_data,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt0,
   output logic [CNT_W-1:0] done_cnt1
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_RESP
   } state_t;

   state_t r_state;
   state_t w_next;

   logic             r_last;
   logic             r_id;
   logic [7:0]       r_data;
   logic [7:0]       r_acc;
   logic [7:0]       r_mcand;
   logic [3:0]       r_mplier;
   logic [1:0]       r_iter;
   logic [CNT_W-1:0] r_cnt0;
   logic [CNT_W-1:0] r_cnt1;

   logic       w_any;
   logic       w_gnt;
   logic       w_acc;
   logic       w_fin;
   logic [2:0] w_op;
   logic [3:0] w_a;
   logic [3:0] w_b;
   logic [4:0] w_sum;
   logic [7:0] w_res;
   logic [7:0] w_acc_nxt;

   // On a tie the requester that did not win last time gets the grant.
   assign w_any = |req_valid;
   assign w_gnt = req_valid[0] ? (req_valid[1] & ~r_last) : 1'b1;
   assign w_acc = (r_state == S_IDLE) & w_any;
   assign w_fin = (r_state == S_RESP) & rsp_ready;

   assign w_op  = w_gnt ? req_op1 : req_op0;
   assign w_a   = w_gnt ? req_a1  : req_a0;
   assign w_b   = w_gnt ? req_b1  : req_b0;
   assign w_sum = {1'b0, w_a} + {1'b0, w_b};

   always_comb begin
      w_res = 8'h00;
      case (w_op)
         3'd0:    w_res = {3'b000, w_sum};
         3'd1:    w_res = {7'd0, |(w_a | w_b)};
         3'd2:    w_res = {7'd0, &(w_a & w_b)};
         3'd3:    w_res = {w_a, w_b};
         default: w_res = 8'h00;
      endcase
   end

   assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_acc) w_next = (w_op == 3'd4) ? S_MUL : S_RESP;
         end
         S_MUL: begin
            if (r_iter == 2'd3) w_next = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = 2'b00;
      if (w_acc) req_ready = w_gnt ? 2'b10 : 2'b01;
      rsp_valid = (r_state == S_RESP);
      busy      = (r_state != S_IDLE);
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_last   <= 1'b1;
         r_id     <= 1'b0;
         r_data   <= 8'h00;
         r_acc    <= 8'h00;
         r_mcand  <= 8'h00;
         r_mplier <= 4'h0;
         r_iter   <= 2'd0;
      end else begin
         if (w_acc) begin
            r_last <= w_gnt;
            r_id   <= w_gnt;
            if (w_op == 3'd4) begin
               r_acc    <= 8'h00;
               r_mcand  <= {4'h0, w_a};
               r_mplier <= w_b;
               r_iter   <= 2'd0;
            end else begin
               r_data <= w_res;
            end
         end
         if (r_state == S_MUL) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_iter   <= r_iter + 2'd1;
            if (r_iter == 2'd3) r_data <= w_acc_nxt;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (w_fin) begin
         if (r_id) r_cnt1 <= r_cnt1 + {{(CNT_W-1){1'b0}}, 1'b1};
         else      r_cnt0 <= r_cnt0 + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign rsp_id    = r_id;
   assign rsp_data  = r_data;
   assign done_cnt0 = r_cnt0;
   assign done_cnt1 = r_cnt1;

endmodule
